// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial A-B over WIDTH cycles using one 1-bit subtract cell with a registered borrow.
// Optional signed-overflow flag output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bo
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, res;
  logic [CW-1:0] cnt;
  logic br, d1, br1, d, br2, bout, last;
  logic [WIDTH-1:0] res_next;
`ifdef SERIAL_SUB_OVF_EN
  logic am, bm;
`endif
  assign d1 = sa[0] ^ sb[0];
  assign br1 = ~sa[0] & sb[0];
  assign d = d1 ^ br;
  assign br2 = ~d1 & br;
  assign bout = br1 | br2;
  assign res_next = {d, res[WIDTH-1:1]};
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      res <= '0;
      cnt <= '0;
      br <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bo <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am <= 1'b0;
      bm <= 1'b0;
      ovf <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa <= a;
            sb <= b;
            br <= 1'b0;
            cnt <= '0;
            busy <= 1'b1;
            state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            am <= a[WIDTH-1];
            bm <= b[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          res <= res_next;
          br <= bout;
          sa <= sa >> 1;
          sb <= sb >> 1;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff <= res_next;
            bo <= bout;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf <= (am ^ bm) & (am ^ d);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
